// File: rtl/midi_tx_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : midi_tx_scheduler
//  Description : Arbitrates three MIDI message sources (control, live-play,
//                playback) onto a single byte-wide UART transmit stream.
//                Control has fixed top priority; live and playback share a
//                round-robin pointer. An inter-message idle gap of
//                GAP_CYCLES is inserted after every completed message.
//                Optional running-status compression is enabled by defining
//                the macro MIDI_RUNNING_STATUS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module midi_tx_scheduler #(
    parameter int GAP_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       live_req,
    input  logic [7:0] live_status,
    input  logic [6:0] live_d1,
    input  logic [6:0] live_d2,
    input  logic       pb_req,
    input  logic [7:0] pb_status,
    input  logic [6:0] pb_d1,
    input  logic [6:0] pb_d2,
    input  logic       ctl_req,
    input  logic [7:0] ctl_status,
    input  logic [6:0] ctl_d1,
    input  logic [6:0] ctl_d2,
    output logic       live_ack,
    output logic       pb_ack,
    output logic       ctl_ack,
    output logic [7:0] tx_byte,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic [1:0] grant,
    output logic       busy,
    output logic       drop
);

    localparam logic [2:0] c_ST_IDLE        = 3'd0;
    localparam logic [2:0] c_ST_SEND_STATUS = 3'd1;
    localparam logic [2:0] c_ST_SEND_D1     = 3'd2;
    localparam logic [2:0] c_ST_SEND_D2     = 3'd3;
    localparam logic [2:0] c_ST_GAP         = 3'd4;

    localparam logic [1:0] c_GNT_NONE = 2'd0;
    localparam logic [1:0] c_GNT_CTL  = 2'd1;
    localparam logic [1:0] c_GNT_LIVE = 2'd2;
    localparam logic [1:0] c_GNT_PB   = 2'd3;

    // Counter must hold 0..GAP_CYCLES; keep at least one bit when GAP_CYCLES is 0.
    localparam int                 c_GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'(GAP_CYCLES);

    logic [2:0]         r_state;
    logic [1:0]         r_grant;
    logic               r_rr_live;
    logic [7:0]         r_status;
    logic [6:0]         r_d1;
    logic [6:0]         r_d2;
    logic [c_GAP_W-1:0] r_gap_cnt;
    logic               r_live_ack;
    logic               r_pb_ack;
    logic               r_ctl_ack;
    logic               r_drop;

    logic [1:0] w_win;
    logic [7:0] w_win_status;
    logic [6:0] w_win_d1;
    logic [6:0] w_win_d2;
    logic       w_any_req;
    logic       w_drop_now;
    logic       w_two_byte;
    logic       w_accept;
    logic       w_done;
    logic       w_rs_skip;

    // Pick the winner: control first, then live/playback by round-robin pointer.
    always_comb begin
        w_win        = c_GNT_NONE;
        w_win_status = 8'h00;
        w_win_d1     = 7'h00;
        w_win_d2     = 7'h00;
        if (ctl_req) begin
            w_win        = c_GNT_CTL;
            w_win_status = ctl_status;
            w_win_d1     = ctl_d1;
            w_win_d2     = ctl_d2;
        end else if (live_req && (!pb_req || r_rr_live)) begin
            w_win        = c_GNT_LIVE;
            w_win_status = live_status;
            w_win_d1     = live_d1;
            w_win_d2     = live_d2;
        end else if (pb_req) begin
            w_win        = c_GNT_PB;
            w_win_status = pb_status;
            w_win_d1     = pb_d1;
            w_win_d2     = pb_d2;
        end
    end

    assign w_any_req  = (w_win != c_GNT_NONE);
    assign w_drop_now = (r_state == c_ST_IDLE) && w_any_req && !w_win_status[7];
    assign w_two_byte = (r_status[7:4] == 4'hC) || (r_status[7:4] == 4'hD);
    assign w_accept   = tx_valid && tx_ready;
    assign w_done     = w_accept && (((r_state == c_ST_SEND_D1) && w_two_byte) ||
                                     (r_state == c_ST_SEND_D2));

`ifdef MIDI_RUNNING_STATUS_EN
    logic       r_rs_valid;
    logic [7:0] r_rs_status;

    assign w_rs_skip = r_rs_valid && (w_win_status == r_rs_status);

    // Remember the last status byte that actually went out on the wire.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rs_valid  <= 1'b0;
            r_rs_status <= 8'h00;
        end else if (w_drop_now) begin
            r_rs_valid <= 1'b0;
        end else if ((r_state == c_ST_SEND_STATUS) && tx_ready) begin
            r_rs_valid  <= 1'b1;
            r_rs_status <= r_status;
        end
    end
`else
    assign w_rs_skip = 1'b0;
`endif

    // Message sequencing: grant, byte transmission, then the idle gap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_ST_IDLE;
            r_grant   <= c_GNT_NONE;
            r_rr_live <= 1'b1;
            r_status  <= 8'h00;
            r_d1      <= 7'h00;
            r_d2      <= 7'h00;
            r_gap_cnt <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_any_req) begin
                        r_status <= w_win_status;
                        r_d1     <= w_win_d1;
                        r_d2     <= w_win_d2;
                        if ((w_win == c_GNT_LIVE) || (w_win == c_GNT_PB)) begin
                            r_rr_live <= !r_rr_live;
                        end
                        // A malformed message is acked and dropped without leaving IDLE.
                        if (!w_drop_now) begin
                            r_grant <= w_win;
                            r_state <= w_rs_skip ? c_ST_SEND_D1 : c_ST_SEND_STATUS;
                        end
                    end
                end
                c_ST_SEND_STATUS: begin
                    if (tx_ready) r_state <= c_ST_SEND_D1;
                end
                c_ST_SEND_D1: begin
                    if (tx_ready) r_state <= w_two_byte ? c_ST_GAP : c_ST_SEND_D2;
                end
                c_ST_SEND_D2: begin
                    if (tx_ready) r_state <= c_ST_GAP;
                end
                c_ST_GAP: begin
                    // Owner stays visible through the ack cycle, then releases.
                    if (r_live_ack || r_pb_ack || r_ctl_ack) r_grant <= c_GNT_NONE;
                    if (r_gap_cnt == c_GAP_LAST) begin
                        r_state   <= c_ST_IDLE;
                        r_gap_cnt <= '0;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    // One-cycle completion and drop pulses, issued the cycle after the deciding edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_live_ack <= 1'b0;
            r_pb_ack   <= 1'b0;
            r_ctl_ack  <= 1'b0;
            r_drop     <= 1'b0;
        end else begin
            r_live_ack <= (w_done && (r_grant == c_GNT_LIVE)) || (w_drop_now && (w_win == c_GNT_LIVE));
            r_pb_ack   <= (w_done && (r_grant == c_GNT_PB))   || (w_drop_now && (w_win == c_GNT_PB));
            r_ctl_ack  <= (w_done && (r_grant == c_GNT_CTL))  || (w_drop_now && (w_win == c_GNT_CTL));
            r_drop     <= w_drop_now;
        end
    end

    // Byte mux: data bytes carry a zero MSB on the wire.
    always_comb begin
        tx_byte = 8'h00;
        case (r_state)
            c_ST_SEND_STATUS: tx_byte = r_status;
            c_ST_SEND_D1:     tx_byte = {1'b0, r_d1};
            c_ST_SEND_D2:     tx_byte = {1'b0, r_d2};
            default:          tx_byte = 8'h00;
        endcase
    end

    assign tx_valid = (r_state == c_ST_SEND_STATUS) || (r_state == c_ST_SEND_D1) ||
                      (r_state == c_ST_SEND_D2);
    assign busy     = (r_state != c_ST_IDLE);
    assign grant    = (r_state == c_ST_IDLE) ? (rst ? c_GNT_NONE : w_win) : r_grant;
    assign live_ack = r_live_ack;
    assign pb_ack   = r_pb_ack;
    assign ctl_ack  = r_ctl_ack;
    assign drop     = r_drop;

endmodule
`default_nettype wire
